// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, fetches one word per cycle from a
// combinational instruction memory into a small in-order queue, and hands the
// queue head downstream over a valid/ready handshake. A zero word halts fetching;
// a redirect flushes the queue and reloads the PC from any state.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_word,
   output logic [31:0] inst_pc,
   output logic        halted,
   output logic [31:0] fetch_count
);

   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

   typedef enum logic [0:0] {
      S_FETCH = 1'b0,
      S_HALT  = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      fcnt_q, fcnt_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      word_mem_q [QDEPTH];
   logic [31:0]      pc_mem_q   [QDEPTH];

   logic pop_s;
   logic full_s;
   logic fetch_s;
   logic enq_s;

   // Handshake and fetch qualification: a full queue may still fetch when its head leaves this cycle.
   always_comb begin
      pop_s   = (cnt_q != {CNT_W{1'b0}}) && inst_ready;
      full_s  = (cnt_q == FULL_CNT);
      fetch_s = (state_q == S_FETCH) && !redirect_valid && (!full_s || pop_s);
      enq_s   = fetch_s && (imem_data != 32'h0000_0000);
   end

   // Next-state logic: redirect wins over fetch/halt; the pop still completes but the queue is emptied.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      fcnt_d   = fcnt_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (redirect_valid) begin
         state_d  = S_FETCH;
         pc_d     = redirect_pc & 32'hFFFF_FFFC;
         rd_ptr_d = {PTR_W{1'b0}};
         wr_ptr_d = {PTR_W{1'b0}};
         cnt_d    = {CNT_W{1'b0}};
      end else begin
         case (state_q)
            S_FETCH: begin
               if (fetch_s) begin
                  if (imem_data != 32'h0000_0000) begin
                     pc_d     = pc_q + 32'd4;
                     fcnt_d   = fcnt_q + 32'd1;
                     wr_ptr_d = wr_ptr_q + PTR_W'(1);
                  end else begin
                     state_d = S_HALT;
                  end
               end else begin
                  state_d = S_FETCH;
               end
            end
            S_HALT: begin
               state_d = S_HALT;
            end
            default: begin
               state_d = S_FETCH;
            end
         endcase
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         cnt_d = cnt_q + CNT_W'(enq_s) - CNT_W'(pop_s);
      end
   end

   // Control state registers with synchronous reset; reset discards the queue by zeroing the occupancy.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         fcnt_q   <= 32'h0000_0000;
         rd_ptr_q <= {PTR_W{1'b0}};
         wr_ptr_q <= {PTR_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         fcnt_q   <= fcnt_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Queue storage: capture the fetched word together with its PC at the tail.
   always_ff @(posedge clock) begin
      if (enq_s && !reset) begin
         word_mem_q[wr_ptr_q] <= imem_data;
         pc_mem_q[wr_ptr_q]   <= pc_q;
      end else begin
         word_mem_q[wr_ptr_q] <= word_mem_q[wr_ptr_q];
         pc_mem_q[wr_ptr_q]   <= pc_mem_q[wr_ptr_q];
      end
   end

   // Output view of registered state; an empty queue shows zeros so stale entries never leak out.
   always_comb begin
      imem_addr   = pc_q;
      fetch_count = fcnt_q;
      halted      = (state_q == S_HALT);
      inst_valid  = (cnt_q != {CNT_W{1'b0}});
      if (inst_valid) begin
         inst_word = word_mem_q[rd_ptr_q];
         inst_pc   = pc_mem_q[rd_ptr_q];
      end else begin
         inst_word = 32'h0000_0000;
         inst_pc   = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: a small ROM model drives imem_data, directed
// sequences push expected {pc, word} pairs into a scoreboard queue, and a
// monitor pops and compares on every accepted handshake.
module tb_fetch_sequencer;

   logic        clock;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_word;
   logic [31:0] inst_pc;
   logic        halted;
   logic [31:0] fetch_count;

   int          total;
   int          bad;
   logic [63:0] exp_q [$];
   logic [63:0] sb_e;

   fetch_sequencer #(
      .RESET_PC (32'h0040_0000),
      .QDEPTH   (2)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_word      (inst_word),
      .inst_pc        (inst_pc),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   // Program image: a short program at 0x00400000, a 12-word block at 0x00400100
   // ending in a zero word at 0x00400130, and a nonzero pattern outside that window.
   function automatic logic [31:0] rom(input logic [31:0] a);
      logic [31:0] off;
      if (a[31:10] != 22'h00_1000) begin
         return {a[31:2], 2'b11};
      end
      case (a)
         32'h0040_0000: return 32'h2008_0005;
         32'h0040_0004: return 32'h2009_0007;
         32'h0040_0008: return 32'h0109_5020;
         default: begin
            if (a >= 32'h0040_0100 && a < 32'h0040_0130) begin
               off = a - 32'h0040_0100;
               return 32'h1111_0000 | (off >> 2);
            end
            return 32'h0000_0000;
         end
      endcase
   endfunction

   assign imem_data = rom(imem_addr);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] word);
      exp_q.push_back({pc, word});
   endtask

   // Scoreboard monitor: every accepted head must match the oldest expected entry.
   always @(negedge clock) begin
      if (!reset && inst_valid && inst_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected actual_pc=%h required=none", inst_pc);
         end else begin
            sb_e = exp_q.pop_front();
            chk("sb_pc", inst_pc, sb_e[63:32]);
            chk("sb_word", inst_word, sb_e[31:0]);
         end
      end
   end

   initial begin
      total          = 0;
      bad            = 0;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0000_0000;
      inst_ready     = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_word", inst_word, 32'd0);
      chk("rst_pc", inst_pc, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_count", fetch_count, 32'd0);
      chk("rst_addr", imem_addr, 32'h0040_0000);

      // Straight-line program with ready high, ending at the zero word
      push(32'h0040_0000, 32'h2008_0005);
      push(32'h0040_0004, 32'h2009_0007);
      push(32'h0040_0008, 32'h0109_5020);
      reset = 1'b0;
      tick();
      chk("first_valid", {31'd0, inst_valid}, 32'd1);
      chk("first_pc", inst_pc, 32'h0040_0000);
      tick();
      tick();
      chk("pre_halt", {31'd0, halted}, 32'd0);
      tick();
      chk("halt_rise", {31'd0, halted}, 32'd1);
      tick();
      tick();
      chk("halt_count", fetch_count, 32'd3);
      chk("halt_addr", imem_addr, 32'h0040_000C);
      chk("halt_valid", {31'd0, inst_valid}, 32'd0);

      // Back-pressure from reset: two entries fill, then fetch stalls
      reset      = 1'b1;
      inst_ready = 1'b0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("bp_addr", imem_addr, 32'h0040_0008);
      chk("bp_count", fetch_count, 32'd2);
      chk("bp_head", inst_pc, 32'h0040_0000);
      push(32'h0040_0000, 32'h2008_0005);
      push(32'h0040_0004, 32'h2009_0007);
      push(32'h0040_0008, 32'h0109_5020);
      inst_ready = 1'b1;
      tick();
      chk("bp_resume_count", fetch_count, 32'd3);
      for (int i = 0; i < 4; i++) tick();
      chk("bp_halted", {31'd0, halted}, 32'd1);
      chk("bp_drained", exp_q.size(), 32'd0);

      // Redirect while halted restarts fetching; count continues
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0040_0000;
      tick();
      redirect_valid = 1'b0;
      chk("rh_halted", {31'd0, halted}, 32'd0);
      chk("rh_valid", {31'd0, inst_valid}, 32'd0);
      chk("rh_addr", imem_addr, 32'h0040_0000);
      chk("rh_count", fetch_count, 32'd3);
      push(32'h0040_0000, 32'h2008_0005);
      push(32'h0040_0004, 32'h2009_0007);
      push(32'h0040_0008, 32'h0109_5020);
      for (int i = 0; i < 5; i++) tick();
      chk("rh_count2", fetch_count, 32'd6);
      chk("rh_halted2", {31'd0, halted}, 32'd1);

      // Fill the queue at 0x00400100, then fetch and pop on the same edge
      inst_ready     = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0040_0103;
      tick();
      redirect_valid = 1'b0;
      chk("fq_addr0", imem_addr, 32'h0040_0100);
      for (int i = 0; i < 3; i++) tick();
      chk("fq_count", fetch_count, 32'd8);
      chk("fq_addr", imem_addr, 32'h0040_0108);
      chk("fq_word", inst_word, 32'h1111_0000);
      push(32'h0040_0100, 32'h1111_0000);
      push(32'h0040_0104, 32'h1111_0001);
      push(32'h0040_0108, 32'h1111_0002);
      push(32'h0040_010C, 32'h1111_0003);
      inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fq_step_count", fetch_count, 32'(9 + i));
         chk("fq_step_valid", {31'd0, inst_valid}, 32'd1);
      end
      chk("fq_addr_end", imem_addr, 32'h0040_0114);

      // Redirect with two entries queued: head pops, the other is discarded
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0040_0103;
      tick();
      redirect_valid = 1'b0;
      chk("rd_valid_gap", {31'd0, inst_valid}, 32'd0);
      chk("rd_addr", imem_addr, 32'h0040_0100);
      chk("rd_count", fetch_count, 32'd11);
      for (int k = 0; k < 12; k++) begin
         push(32'h0040_0100 + 32'(4 * k), 32'h1111_0000 + 32'(k));
      end
      tick();
      chk("rd_target_pc", inst_pc, 32'h0040_0100);
      for (int i = 0; i < 15; i++) tick();
      chk("rd_halted", {31'd0, halted}, 32'd1);
      chk("rd_count_end", fetch_count, 32'd23);
      chk("rd_drained", exp_q.size(), 32'd0);

      // PC wrap from 0xFFFFFFFC to 0
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      push(32'hFFFF_FFFC, 32'hFFFF_FFFF);
      tick();
      chk("wrap_addr", imem_addr, 32'h0000_0000);
      chk("wrap_count", fetch_count, 32'd24);
      tick();
      inst_ready = 1'b0;
      tick();
      tick();
      chk("wrap_full_addr", imem_addr, 32'h0000_0008);
      chk("wrap_full_count", fetch_count, 32'd26);

      // One-cycle reset with a full queue
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_valid", {31'd0, inst_valid}, 32'd0);
      chk("mr_addr", imem_addr, 32'h0040_0000);
      chk("mr_count", fetch_count, 32'd0);
      chk("mr_halted", {31'd0, halted}, 32'd0);
      tick();
      chk("end_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
